// File: rtl/multicycle_control_if.sv
// Signal bundle between the multi-cycle RV32I control FSM and its datapath/memories.
// The control FSM connects through the master modport; the datapath side uses slave.
interface multicycle_control_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int INSTRET_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]    instr;
    logic                     is_alu_reg, is_alu_imm, is_branch, is_jal, is_jalr;
    logic                     is_lui, is_auipc, is_load, is_store, is_system;
    logic                     branch_taken, imem_ready, dmem_ready, trap_ack;
    logic                     imem_req, ir_write, dmem_req, mem_read, mem_write, reg_write;
    logic [1:0]               wb_sel;
    logic                     alu_src;
    logic [1:0]               alu_op;
    logic [2:0]               imm_sel;
    logic                     branch_sig, jump, pc_write;
    logic [1:0]               pc_src;
    logic                     trap;
    logic [3:0]               trap_cause;
    logic [INSTRET_WIDTH-1:0] instret;
    logic [2:0]               state;

    modport master (
        input  instr, is_alu_reg, is_alu_imm, is_branch, is_jal, is_jalr,
               is_lui, is_auipc, is_load, is_store, is_system,
               branch_taken, imem_ready, dmem_ready, trap_ack,
        output imem_req, ir_write, dmem_req, mem_read, mem_write, reg_write,
               wb_sel, alu_src, alu_op, imm_sel, branch_sig, jump, pc_write,
               pc_src, trap, trap_cause, instret, state
    );

    modport slave (
        output instr, is_alu_reg, is_alu_imm, is_branch, is_jal, is_jalr,
               is_lui, is_auipc, is_load, is_store, is_system,
               branch_taken, imem_ready, dmem_ready, trap_ack,
        input  imem_req, ir_write, dmem_req, mem_read, mem_write, reg_write,
               wb_sel, alu_src, alu_op, imm_sel, branch_sig, jump, pc_write,
               pc_src, trap, trap_cause, instret, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for RV32I: fetch/decode/execute/mem/writeback with
// ready handshakes, optional wait-state timeout, precise traps and retire counting.
module multicycle_control #(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_TIMEOUT   = 16,
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    localparam logic [DATA_WIDTH-1:0] INSTR_ECALL  = DATA_WIDTH'(32'h0000_0073);
    localparam logic [DATA_WIDTH-1:0] INSTR_EBREAK = DATA_WIDTH'(32'h0010_0073);
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam int C_ALU_REG = 0, C_ALU_IMM = 1, C_BRANCH = 2, C_JAL = 3, C_JALR = 4;
    localparam int C_LUI = 5, C_AUIPC = 6, C_LOAD = 7, C_STORE = 8;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    state_t                   r_state, w_state_next;
    logic [8:0]               r_class;
    logic [WAIT_W-1:0]        r_wait;
    logic [3:0]               r_trap_cause, w_cause_next;
    logic [INSTRET_WIDTH-1:0] r_instret;
    logic [9:0]               w_flags;
    logic                     w_onehot, w_timeout, w_waiting, w_retire, w_trap_enter, w_is_jump;
    logic [1:0]               w_alu_op;
    logic                     w_alu_src;
    logic [2:0]               w_imm_sel;

    assign w_flags = {bus.is_system, bus.is_store, bus.is_load, bus.is_auipc, bus.is_lui,
                      bus.is_jalr, bus.is_jal, bus.is_branch, bus.is_alu_imm, bus.is_alu_reg};
    assign w_onehot  = (w_flags != 10'd0) && ((w_flags & (w_flags - 10'd1)) == 10'd0);
    // Timeout fires on the cycle the count would reach MEM_TIMEOUT; ready still wins.
    assign w_timeout = (MEM_TIMEOUT > 0) && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));
    assign w_waiting = ((r_state == S_FETCH) && !bus.imem_ready) ||
                       ((r_state == S_MEM) && !bus.dmem_ready);
    assign w_is_jump = r_class[C_JAL] | r_class[C_JALR];

    assign bus.trap_cause = r_trap_cause;
    assign bus.instret    = r_instret;
    assign bus.state      = r_state;

    // ALU setup from the latched class, kept stable from EXECUTE through WB.
    always_comb begin
        w_alu_op  = 2'b00;
        w_alu_src = 1'b0;
        w_imm_sel = IMM_NONE;
        if (r_class[C_ALU_REG]) begin
            w_alu_op = 2'b10;
        end else if (r_class[C_ALU_IMM]) begin
            w_alu_op = 2'b10; w_alu_src = 1'b1; w_imm_sel = IMM_I;
        end else if (r_class[C_BRANCH]) begin
            w_alu_op = 2'b01; w_imm_sel = IMM_B;
        end else if (r_class[C_LUI]) begin
            w_alu_op = 2'b11; w_alu_src = 1'b1; w_imm_sel = IMM_U;
        end else if (r_class[C_AUIPC]) begin
            w_alu_src = 1'b1; w_imm_sel = IMM_U;
        end else if (r_class[C_JAL]) begin
            w_alu_src = 1'b1; w_imm_sel = IMM_J;
        end else if (r_class[C_STORE]) begin
            w_alu_src = 1'b1; w_imm_sel = IMM_S;
        end else if (r_class[C_LOAD] || r_class[C_JALR]) begin
            w_alu_src = 1'b1; w_imm_sel = IMM_I;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_retire       = 1'b0;
        w_trap_enter   = 1'b0;
        w_cause_next   = r_trap_cause;
        bus.imem_req   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.wb_sel     = 2'b00;
        bus.alu_src    = 1'b0;
        bus.alu_op     = 2'b00;
        bus.imm_sel    = IMM_NONE;
        bus.branch_sig = 1'b0;
        bus.jump       = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'b00;
        bus.trap       = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ready) begin
                        bus.ir_write = 1'b1;
                        w_state_next = S_DECODE;
                    end else if (w_timeout) begin
                        w_trap_enter = 1'b1; w_cause_next = 4'd1; w_state_next = S_TRAP;
                    end
                end
                S_DECODE: begin
                    if (!w_onehot || (bus.is_system && (bus.instr != INSTR_ECALL) &&
                                      (bus.instr != INSTR_EBREAK))) begin
                        w_trap_enter = 1'b1; w_cause_next = 4'd2; w_state_next = S_TRAP;
                    end else if (bus.is_system) begin
                        w_trap_enter = 1'b1;
                        w_cause_next = (bus.instr == INSTR_ECALL) ? 4'd11 : 4'd3;
                        w_state_next = S_TRAP;
                    end else begin
                        w_state_next = S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    bus.alu_op     = w_alu_op;
                    bus.alu_src    = w_alu_src;
                    bus.imm_sel    = w_imm_sel;
                    bus.branch_sig = r_class[C_BRANCH];
                    bus.jump       = w_is_jump;
                    if (r_class[C_BRANCH]) begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = bus.branch_taken ? 2'b01 : 2'b00;
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end else if (r_class[C_LOAD] || r_class[C_STORE]) begin
                        w_state_next = S_MEM;
                    end else begin
                        w_state_next = S_WB;
                    end
                end
                S_MEM: begin
                    bus.alu_op    = w_alu_op;
                    bus.alu_src   = w_alu_src;
                    bus.imm_sel   = w_imm_sel;
                    bus.dmem_req  = 1'b1;
                    bus.mem_read  = r_class[C_LOAD];
                    bus.mem_write = r_class[C_STORE];
                    if (bus.dmem_ready) begin
                        if (r_class[C_LOAD]) begin
                            w_state_next = S_WB;
                        end else begin
                            bus.pc_write = 1'b1;
                            w_retire     = 1'b1;
                            w_state_next = S_FETCH;
                        end
                    end else if (w_timeout) begin
                        w_trap_enter = 1'b1;
                        w_cause_next = r_class[C_LOAD] ? 4'd5 : 4'd7;
                        w_state_next = S_TRAP;
                    end
                end
                S_WB: begin
                    bus.alu_op    = w_alu_op;
                    bus.alu_src   = w_alu_src;
                    bus.imm_sel   = w_imm_sel;
                    bus.reg_write = 1'b1;
                    bus.wb_sel    = r_class[C_LOAD] ? 2'b01 : (w_is_jump ? 2'b10 : 2'b00);
                    bus.pc_write  = 1'b1;
                    bus.pc_src    = w_is_jump ? 2'b01 : 2'b00;
                    w_retire      = 1'b1;
                    w_state_next  = S_FETCH;
                end
                S_TRAP: begin
                    bus.trap = 1'b1;
                    if (bus.trap_ack) begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 2'b10;
                        w_state_next = S_FETCH;
                    end
                end
                default: w_state_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_class      <= '0;
            r_wait       <= '0;
            r_trap_cause <= '0;
            r_instret    <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_class <= w_flags[8:0];
            end
            if (w_state_next != r_state) begin
                r_wait <= '0;
            end else if (w_waiting) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            if (w_trap_enter) begin
                r_trap_cause <= w_cause_next;
            end
            if (w_retire) begin
                r_instret <= r_instret + INSTRET_WIDTH'(1);
            end
        end
    end
endmodule
